div_ctrl: RTL

- Execute-stage front end for the 32-bit divider core.
- Accepts a DIV/MOD op from the EX issue logic and launches one request on the core's dividend/divisor valid strobes.
- Stalls the pipeline until the core's result returns, then selects the quotient or remainder and presents it for one cycle.
- Bypasses the core for divide-by-zero and signed overflow, and keeps a stale in-flight result from reaching the pipeline after a flush.

---
 rtl/div_ctrl_pkg.sv | 23 ++
 rtl/div_ctrl_if.sv | 39 +++
 rtl/div_special_detect.sv | 24 ++
 rtl/div_ctrl.sv | 118 +++++++++++
 4 files changed

// File: rtl/div_ctrl_pkg.sv
// Shared execution-stage definitions for the divider front end:
// FSM encodings, bypass constants and core result field positions.
package div_ctrl_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_DRAIN = 3'd4
  } div_state_t;

  localparam logic [XLEN-1:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0] INT_MIN   = 32'h8000_0000;
  localparam logic [XLEN-1:0] NEG_ONE   = 32'hFFFF_FFFF;

  // Core result bus: quotient in the upper half, remainder in the lower half.
  localparam int QUOT_LSB = XLEN;
  localparam int REM_LSB  = 0;

endpackage

// File: rtl/div_ctrl_if.sv
// Bundle between EX issue logic / divider core and the divider front end.
// slave is the div_ctrl view, master is the environment view.
interface div_ctrl_if #(
  parameter int DATA_WIDTH = 32
);
  logic                    flush;
  logic                    op_valid_i;
  logic                    op_signed_i;
  logic                    op_rem_i;
  logic [DATA_WIDTH-1:0]   op_src1_i;
  logic [DATA_WIDTH-1:0]   op_src2_i;
  logic                    stall_o;
  logic                    result_valid_o;
  logic [DATA_WIDTH-1:0]   result_o;
  logic                    timeout_o;
  logic [DATA_WIDTH-1:0]   div_dividend_o;
  logic [DATA_WIDTH-1:0]   div_divisor_o;
  logic                    div_dividend_valid_o;
  logic                    div_divisor_valid_o;
  logic                    div_signed_o;
  logic                    div_ready_i;
  logic [2*DATA_WIDTH-1:0] div_result_i;

  modport slave (
    input  flush, op_valid_i, op_signed_i, op_rem_i, op_src1_i, op_src2_i,
           div_ready_i, div_result_i,
    output stall_o, result_valid_o, result_o, timeout_o,
           div_dividend_o, div_divisor_o, div_dividend_valid_o,
           div_divisor_valid_o, div_signed_o
  );

  modport master (
    output flush, op_valid_i, op_signed_i, op_rem_i, op_src1_i, op_src2_i,
           div_ready_i, div_result_i,
    input  stall_o, result_valid_o, result_o, timeout_o,
           div_dividend_o, div_divisor_o, div_dividend_valid_o,
           div_divisor_valid_o, div_signed_o
  );
endinterface

// File: rtl/div_special_detect.sv
// Flags operand pairs the divider core must not see (zero divisor,
// signed INT_MIN / -1) and produces the architectural bypass results.
module div_special_detect
  import div_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = XLEN
) (
  input  logic [DATA_WIDTH-1:0] src1,
  input  logic [DATA_WIDTH-1:0] src2,
  input  logic                  is_signed,
  output logic                  div_zero,
  output logic                  overflow,
  output logic [DATA_WIDTH-1:0] bypass_quot,
  output logic [DATA_WIDTH-1:0] bypass_rem
);

  always_comb begin
    div_zero    = (src2 == '0);
    overflow    = is_signed && (src1 == INT_MIN) && (src2 == NEG_ONE);
    bypass_quot = div_zero ? DIV0_QUOT : INT_MIN;
    bypass_rem  = div_zero ? src1 : '0;
  end

endmodule

// File: rtl/div_ctrl.sv
// Execute-stage divider front end: launches one core request per op, stalls
// until the result returns, bypasses special cases and drains flushed ops.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = XLEN,
  parameter int MAX_WAIT   = 64
) (
  input logic     clk,
  input logic     rst,
  div_ctrl_if.slave bus
);

  div_state_t            state;
  logic [DATA_WIDTH-1:0] src1_q;
  logic [DATA_WIDTH-1:0] src2_q;
  logic [DATA_WIDTH-1:0] res_q;
  logic [DATA_WIDTH-1:0] cnt;
  logic                  sgn_q;
  logic                  rem_q;
  logic                  strobe_q;
  logic                  timeout_q;

  logic                  div_zero;
  logic                  overflow;
  logic [DATA_WIDTH-1:0] byp_quot;
  logic [DATA_WIDTH-1:0] byp_rem;
  logic [DATA_WIDTH-1:0] cnt_inc;
  logic                  wait_expired;
  logic                  accept;

  div_special_detect #(.DATA_WIDTH(DATA_WIDTH)) u_detect (
    .src1        (bus.op_src1_i),
    .src2        (bus.op_src2_i),
    .is_signed   (bus.op_signed_i),
    .div_zero    (div_zero),
    .overflow    (overflow),
    .bypass_quot (byp_quot),
    .bypass_rem  (byp_rem)
  );

  assign accept       = (state == ST_IDLE) && bus.op_valid_i && !bus.flush;
  assign cnt_inc      = (cnt == '1) ? cnt : cnt + 1'b1;
  assign wait_expired = (cnt_inc >= DATA_WIDTH'(MAX_WAIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      src1_q    <= '0;
      src2_q    <= '0;
      res_q     <= '0;
      cnt       <= '0;
      sgn_q     <= 1'b0;
      rem_q     <= 1'b0;
      strobe_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (div_zero || overflow) begin
              res_q <= bus.op_rem_i ? byp_rem : byp_quot;
              state <= ST_DONE;
            end else begin
              src1_q   <= bus.op_src1_i;
              src2_q   <= bus.op_src2_i;
              sgn_q    <= bus.op_signed_i;
              rem_q    <= bus.op_rem_i;
              strobe_q <= 1'b1;
              state    <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          cnt   <= '0;
          state <= bus.flush ? ST_DRAIN : ST_WAIT;
        end
        ST_WAIT: begin
          cnt <= cnt_inc;
          // A flush that coincides with the core answer (or expiry) has nothing left to drain.
          if (bus.flush) begin
            state <= (bus.div_ready_i || wait_expired) ? ST_IDLE : ST_DRAIN;
          end else if (bus.div_ready_i) begin
            res_q <= rem_q ? bus.div_result_i[REM_LSB +: DATA_WIDTH]
                           : bus.div_result_i[QUOT_LSB +: DATA_WIDTH];
            state <= ST_DONE;
          end else if (wait_expired) begin
            res_q     <= '0;
            timeout_q <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DRAIN: begin
          cnt <= cnt_inc;
          if (bus.div_ready_i || wait_expired) state <= ST_IDLE;
        end
        ST_DONE: begin
          res_q <= '0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.stall_o              = accept || (state == ST_ISSUE) ||
                                    (state == ST_WAIT) || (state == ST_DRAIN);
  assign bus.result_valid_o       = (state == ST_DONE) && !bus.flush;
  assign bus.result_o             = res_q;
  assign bus.timeout_o            = timeout_q;
  assign bus.div_dividend_o       = src1_q;
  assign bus.div_divisor_o        = src2_q;
  assign bus.div_dividend_valid_o = strobe_q;
  assign bus.div_divisor_valid_o  = strobe_q;
  assign bus.div_signed_o         = sgn_q;

endmodule
